rr_grant_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource (e.g. a bus port or execution slot) between N requesters.
- Each grant is issued as both one-hot and binary-encoded and held until the owner releases it.
- Sits between the requester bank and the shared datapath.
- Its internal pick logic is a masked priority encoder.

---
 rtl/rr_arb_pkg.sv | 28 ++
 rtl/mask_prio_pick.sv | 33 +++
 rtl/rr_grant_arbiter.sv | 104 ++++++++++
 tb/tb_rr_grant_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types, default sizes and the one-hot-to-index helper for the round-robin grant arbiter.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_N_REQ          = 8;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    // Widest request vector the helper accepts; callers zero-extend.
    localparam int MAX_REQ  = 32;
    localparam int MAX_ID_W = 5;

    function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mask_prio_pick.sv
// Combinational round-robin pick: lowest request strictly above last_id, else lowest request overall.
module mask_prio_pick
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic [ID_W-1:0]  pick,
    output logic             any_req
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] search;
    logic [N_REQ-1:0] lsb;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (i > int'(last_id));
        end
    end

    assign masked = req & mask;
    assign search = (masked != '0) ? masked : req;
    // Two's-complement trick isolates the lowest set bit.
    assign lsb     = search & (~search + N_REQ'(1));
    assign pick    = ID_W'(onehot_to_idx(MAX_REQ'(lsb)));
    assign any_req = |req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with held grants and a one-cycle bubble after each release.
// Optional forced-release watchdog is built when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ          = DEF_N_REQ,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int ID_W           = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout_err
);

    if ((N_REQ < 2) || ((N_REQ & (N_REQ - 1)) != 0) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
        $error("rr_grant_arbiter: N_REQ must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
    end

    state_t          state;
    logic [ID_W-1:0] last_id;
    logic [ID_W-1:0] pick;
    logic            any_req;
    logic            natural_rel;
    logic            forced;
    logic            release_now;

    mask_prio_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req),
        .last_id (last_id),
        .pick    (pick),
        .any_req (any_req)
    );

    // Only the owner's done/req lines matter; everything else is ignored while busy.
    assign natural_rel = done[gnt_id] | ~req[gnt_id];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] hold_cnt;
    assign forced = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign forced = 1'b0;
`endif

    assign release_now = natural_rel | forced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_id     <= ID_W'(N_REQ - 1);
            gnt         <= '0;
            gnt_id      <= '0;
            gnt_valid   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= N_REQ'(1) << pick;
                        gnt_id    <= pick;
                        gnt_valid <= 1'b1;
                        last_id   <= pick;
                        state     <= BUSY;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        gnt         <= '0;
                        gnt_id      <= '0;
                        gnt_valid   <= 1'b0;
                        timeout_err <= forced & ~natural_rel;
                        state       <= GAP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`endif
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter; the watchdog scenario runs when ARB_TIMEOUT_EN is defined.
module tb_rr_grant_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 256;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    rr_grant_arbiter #(
        .N_REQ          (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .gnt_valid   (gnt_valid),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                              input logic e_valid, input logic e_terr);
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'(e_terr));
    endtask

    task automatic expect_grant(input string tag, input int id);
        logic [7:0] oh;
        oh = 8'(1) << id;
        expect_out(tag, oh, 3'(id), 1'b1, 1'b0);
    endtask

    task automatic expect_idle(input string tag);
        expect_out(tag, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    // Pulse done for the owner, then observe the GAP and IDLE bubble.
    task automatic release_done(input string tag, input int id);
        done = 8'(1) << id;
        step();
        done = 8'h00;
        expect_idle({tag, ".gap"});
        step();
        expect_idle({tag, ".idle"});
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 8'h00;
        done  = 8'h00;
        #2 rst_n = 1'b0;
        step();
        step();
        expect_idle("reset");
        rst_n = 1'b1;

        // Single requester: one-cycle latency, then two cleared cycles.
        req = 8'h01;
        step();
        expect_grant("t1.grant", 0);
        release_done("t1.rel", 0);
        step();
        expect_grant("t1.regrant", 0);
        req = 8'h00;
        step();
        expect_idle("t1.drop.gap");
        step();
        expect_idle("t1.drop.idle");

        // Full rotation after a fresh reset.
        #3 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            step();
            expect_grant($sformatf("t2.grant%0d", k), k % 8);
            release_done($sformatf("t2.rel%0d", k), k % 8);
        end
        req = 8'h00;
        step();
        expect_idle("t2.quiet");

        // Wrap from last_id=5.
        req = 8'h20;
        step();
        expect_grant("t3.grant5", 5);
        done = 8'h20;
        step();
        done = 8'h00;
        req  = 8'h26;
        expect_idle("t3.gap");
        step();
        expect_idle("t3.idle");
        step();
        expect_grant("t3.wrap1", 1);
        release_done("t3.rel1", 1);
        step();
        expect_grant("t3.next2", 2);
        release_done("t3.rel2", 2);
        step();
        expect_grant("t3.next5", 5);

        // Noise on other lines must not disturb the owner.
        req = 8'h00;
        step();
        expect_idle("t4.gap");
        req = 8'h08;
        step();
        expect_idle("t4.idle");
        step();
        expect_grant("t4.grant3", 3);
        done = 8'h10;
        step();
        done = 8'h00;
        expect_grant("t4.done4", 3);
        req = 8'h48;
        step();
        expect_grant("t4.req6", 3);
        req = 8'h08;
        step();
        expect_grant("t4.req6off", 3);
        req = 8'h00;
        step();
        expect_idle("t4.rel.gap");
        step();
        expect_idle("t4.rel.idle");
        done = 8'hFF;
        step();
        done = 8'h00;
        expect_idle("t4.done_idle");

        // Asynchronous reset mid-grant, then last_id restarts at 7.
        req = 8'h04;
        step();
        expect_grant("t5.grant2", 2);
        #2 rst_n = 1'b0;
        #1;
        expect_idle("t5.async");
        step();
        rst_n = 1'b1;
        req = 8'h80;
        step();
        expect_grant("t5.grant7", 7);
        req  = 8'h00;
        done = 8'h80;
        step();
        done = 8'h00;
        expect_idle("t5.both.gap");
        step();
        expect_idle("t5.both.idle");
        step();
        expect_idle("t5.both.stay");
        req = 8'h81;
        step();
        expect_grant("t5.grant0", 0);
        req = 8'h80;
        step();
        expect_idle("t5.drop0.gap");
        step();
        expect_idle("t5.drop0.idle");
        step();
        expect_grant("t5.grant7b", 7);
        req = 8'h00;
        step();
        step();
        expect_idle("t5.end");

`ifdef ARB_TIMEOUT_EN
        // Owner 2 never releases; watchdog frees it after 4 busy cycles.
        req = 8'h14;
        for (int c = 1; c <= 4; c++) begin
            step();
            expect_grant($sformatf("t6.hold%0d", c), 2);
        end
        step();
        expect_out("t6.forced", 8'h00, 3'd0, 1'b0, 1'b1);
        step();
        expect_idle("t6.idle");
        step();
        expect_grant("t6.next4", 4);
`else
        // Without the watchdog a grant is held indefinitely.
        req = 8'h14;
        for (int c = 1; c <= 20; c++) begin
            step();
            expect_grant($sformatf("t6.hold%0d", c), 2);
        end
        req = 8'h10;
        step();
        expect_idle("t6.gap");
        step();
        expect_idle("t6.idle");
        step();
        expect_grant("t6.next4", 4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
